// File: rtl/key_msg_gen.sv
// Turns single-cycle key presses into short ASCII messages of the form
// "K<idx> <HH>\r\n", one byte at a time over a valid/ready handshake.
// HH is the running message count in upper-case hex.
// Presses that arrive while a message is being sent are queued in a
// pending mask and served lowest index first.
module key_msg_gen #(
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_down,
  input  logic             tx_rdy,
  output logic             tx_vld,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             evt_lost,
  output logic [7:0]       press_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] pending_q, pending_d;
  logic [KEY_W-1:0] clr_mask;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [3:0]       key_idx_q, key_idx_d;
  logic [3:0]       sel_idx;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic [7:0]       cnt_snap_q, cnt_snap_d;
  logic             tx_vld_q;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             evt_lost_q, evt_lost_d;
  logic             take;

  // Upper-case ASCII hex digit for a nibble.
  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte at a given position of the message "K<key> <snap>\r\n".
  function automatic logic [7:0] msgByte(input logic [2:0] idx,
                                         input logic [3:0] key,
                                         input logic [7:0] snap);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h4B;
      3'd1:    b = 8'h30 + {4'h0, key};
      3'd2:    b = 8'h20;
      3'd3:    b = hexChar(snap[7:4]);
      3'd4:    b = hexChar(snap[3:0]);
      3'd5:    b = 8'h0D;
      3'd6:    b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state logic: pick the lowest pending key, step through the bytes
  // on each accepted transfer, and merge new presses into the pending mask
  // (a new press beats a same-cycle clear; a press on an already-waiting
  // key is dropped and reported).
  always_comb begin
    sel_idx = 4'd0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 4'(i);
    end

    take = (state_q == IDLE) && (|pending_q);

    clr_mask = '0;
    for (int i = 0; i < KEY_W; i++) begin
      clr_mask[i] = take && (sel_idx == 4'(i));
    end

    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    key_idx_d   = key_idx_q;
    press_cnt_d = press_cnt_q;
    cnt_snap_d  = cnt_snap_q;

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d     = SEND;
          key_idx_d   = sel_idx;
          press_cnt_d = press_cnt_q + 8'd1;
          cnt_snap_d  = press_cnt_q + 8'd1;
          byte_idx_d  = 3'd0;
        end
      end
      SEND: begin
        if (tx_rdy) begin
          if (byte_idx_q == 3'd6) begin
            state_d    = IDLE;
            byte_idx_d = 3'd0;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d  = (pending_q & ~clr_mask) | key_down;
    evt_lost_d = |(key_down & pending_q & ~clr_mask);
    tx_data_d  = (state_d == SEND) ? msgByte(byte_idx_d, key_idx_d, cnt_snap_d) : 8'h00;
  end

  // All state and registered outputs; reset abandons any message in flight
  // and ignores presses arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      byte_idx_q  <= 3'd0;
      key_idx_q   <= 4'd0;
      press_cnt_q <= 8'h00;
      cnt_snap_q  <= 8'h00;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      evt_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      byte_idx_q  <= byte_idx_d;
      key_idx_q   <= key_idx_d;
      press_cnt_q <= press_cnt_d;
      cnt_snap_q  <= cnt_snap_d;
      tx_vld_q    <= (state_d == SEND);
      tx_data_q   <= tx_data_d;
      evt_lost_q  <= evt_lost_d;
    end
  end

  assign tx_vld    = tx_vld_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q == SEND);
  assign evt_lost  = evt_lost_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: doc/key_msg_gen.md
KEY_MSG_GEN -- requirements
Module: key_msg_gen

Interface
REQ-001 SHALL have parameter KEY_W, default 4, number of key event inputs; legal range 1..10.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_down  input  KEY_W  one-cycle press pulses from the debounce stage; any bit combination legal.
REQ-005 SHALL have port tx_rdy  input  1  downstream UART transmitter ready to accept a byte.
REQ-006 SHALL have port tx_vld  output  1  tx_data holds a valid byte.
REQ-007 SHALL have port tx_data  output  8  ASCII byte to transmit.
REQ-008 SHALL have port busy  output  1  high while a message is in progress (state SEND).
REQ-009 SHALL have port evt_lost  output  1  one-cycle pulse when a press is discarded.
REQ-010 SHALL have port press_cnt  output  8  count of messages started, wraps 0xFF->0x00.

Function
REQ-011 SHALL keep a KEY_W-bit pending mask; a key_down bit sets its pending bit on the next clock edge.
REQ-012 SHALL, when key_down[i] is asserted while pending[i] is already set and is not being cleared in the same cycle, keep pending[i] set and pulse evt_lost for one cycle the next cycle.
REQ-013 SHALL, when pending[i] is cleared and key_down[i] is asserted in the same cycle, leave pending[i] set (set wins) with no evt_lost.
REQ-014 SHALL implement a two-state FSM: IDLE and SEND.
REQ-015 SHALL, in IDLE with pending != 0, in one cycle: select the lowest-index set bit i, clear pending[i], latch key_idx=i, increment press_cnt, latch cnt_snap=new press_cnt value, set byte_idx=0, and go to SEND.
REQ-016 SHALL, in IDLE with pending == 0, remain in IDLE with tx_vld=0.
REQ-017 SHALL in SEND drive tx_vld=1 and tx_data by byte_idx: 0:'K'(0x4B), 1:0x30+key_idx, 2:' '(0x20), 3:upper-case hex of cnt_snap[7:4], 4:upper-case hex of cnt_snap[3:0], 5:0x0D, 6:0x0A.
REQ-018 SHALL treat a byte as transferred only in a cycle with tx_vld=1 and tx_rdy=1; tx_data SHALL remain stable while tx_vld=1 and tx_rdy=0.
REQ-019 SHALL advance byte_idx by one on each transfer; on the transfer of byte 6 it SHALL return to IDLE, with tx_vld=0 the following cycle.
REQ-020 SHALL NOT accept tx_rdy while in IDLE; tx_vld SHALL never assert in IDLE.
REQ-021 SHALL give latency: key_down at cycle N with FSM in IDLE and pending==0 -> pending set at N+1 -> SEND entered at N+2 with first byte valid.
REQ-022 SHALL keep accepting key_down into pending while in SEND; queued keys are served in index order after the current message ends, one IDLE cycle between messages.
REQ-023 SHALL hold busy equal to (state==SEND).

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set state=IDLE, pending=0, press_cnt=0, byte_idx=0, key_idx=0, cnt_snap=0, tx_vld=0, tx_data=0x00, busy=0, evt_lost=0.
REQ-025 SHALL abort any message in progress on reset without completing remaining bytes; key_down in the reset cycle SHALL be ignored.

Verification
REQ-026 Single press: key_down=4'b0100 one cycle, tx_rdy=1 -> bytes 4B 32 20 30 31 0D 0A, press_cnt=0x01, busy high exactly 7 cycles.
REQ-027 Backpressure: as REQ-026, with tx_rdy=0 for 5 cycles during byte 3 -> tx_data holds 0x30 stable, no byte skipped or duplicated.
REQ-028 Simultaneous: key_down=4'b1001 -> message "K0 01\r\n" then "K3 02\r\n", one IDLE cycle between.
REQ-029 Loss: press key 1 during SEND, again 3 cycles later -> one evt_lost pulse, exactly one "K1" message follows.
REQ-030 Wrap: 256 presses of key 0 -> the 256th message carries "00", press_cnt=0x00.
REQ-031 Reset mid-message: rst=1 during byte 2 -> next cycle tx_vld=0, busy=0, press_cnt=0, pending=0; new press then produces "K<i> 01\r\n".
